// File: rtl/vg_trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vg_trap_pkg
//  Purpose  : Shared types and constants for the VG93 trap controller.
//  Revision : 1.0 - initial release
// ============================================================================
package vg_trap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] REG_STAT = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_CNTL = 2'd2;
    localparam logic [1:0] REG_CNTH = 2'd3;

    localparam int STAT_ACTIVE = 7;
    localparam int STAT_WR     = 6;
    localparam int STAT_ERR    = 5;
    localparam int STAT_OVF    = 4;
    localparam int STAT_A_MSB  = 1;
    localparam int STAT_A_LSB  = 0;

endpackage
`default_nettype wire

// File: rtl/vg_trap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : vg_trap_ctrl_if
//  Purpose  : Z80-side trap inputs and emulator register bus of vg_trap_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface vg_trap_ctrl_if;

    logic       vg_rdwr_fclk;
    logic [1:0] vg_a;
    logic       vg_wr;
    logic [7:0] vg_wdata;
    logic [3:0] fdd_mask;
    logic       dos;
    logic       romnram;
    logic       emu_rd;
    logic       emu_wr;
    logic [1:0] emu_addr;
    logic [7:0] emu_wdata;
    logic [7:0] emu_rdata;
    logic       clr_nmi;
    logic       trap_active;
    logic [7:0] vg_rdata;
    logic       vg_rdata_vld;

    modport master (
        output vg_rdwr_fclk, vg_a, vg_wr, vg_wdata, fdd_mask, dos, romnram,
        output emu_rd, emu_wr, emu_addr, emu_wdata,
        input  emu_rdata, clr_nmi, trap_active, vg_rdata, vg_rdata_vld
    );

    modport slave (
        input  vg_rdwr_fclk, vg_a, vg_wr, vg_wdata, fdd_mask, dos, romnram,
        input  emu_rd, emu_wr, emu_addr, emu_wdata,
        output emu_rdata, clr_nmi, trap_active, vg_rdata, vg_rdata_vld
    );

endinterface
`default_nettype wire

// File: rtl/vg_trap_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : vg_trap_timeout
//  Purpose  : Loadable up-counter with a terminal-count flag at TIMEOUT_CYCLES-1.
//  Revision : 1.0 - initial release
// ============================================================================
module vg_trap_timeout #(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load,
    input  wire logic en,
    output logic      tc
);

    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign tc = (r_cnt == W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/vg_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vg_trap_ctrl
//  Purpose  : Captures a trapped VG93 access and hands it to the page-#FE emulator.
//             Optional trap statistics counter enabled by defining TRAP_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module vg_trap_ctrl
    import vg_trap_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CNT_W          = 16
) (
    input  wire logic     fclk,
    input  wire logic     rst,
    vg_trap_ctrl_if.slave bus
);

    localparam int CW = (CNT_W < 16) ? CNT_W : 16;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_trap;
    logic       w_accept;
    logic       w_active;
    logic       w_clr;
    logic       w_rel_wr;
    logic       w_tc;
    logic       w_stat_rd;
    logic       w_err_set;
    logic       w_ovf_set;
    logic       w_resp_wr;
    logic [1:0] r_a;
    logic       r_wr;
    logic [7:0] r_wdata;
    logic       r_err;
    logic       r_ovf;
    logic [7:0] r_vg_rdata;
    logic       r_vg_rdata_vld;
    logic [7:0] w_rdata;
    logic [CNT_W-1:0] w_cnt;
    logic [15:0]      w_cnt_ext;

    // Same qualification that sets in_trdemu in zdos
    assign w_trap    = bus.vg_rdwr_fclk & bus.fdd_mask[bus.vg_a] & bus.dos & bus.romnram;
    assign w_rel_wr  = bus.emu_wr & (bus.emu_addr == REG_STAT) & bus.emu_wdata[0];
    assign w_stat_rd = bus.emu_rd & (bus.emu_addr == REG_STAT);
    assign w_resp_wr = bus.emu_wr & (bus.emu_addr == REG_DATA) & (r_state == HELD) & ~r_wr;

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_active    = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trap) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                w_active = 1'b1;
                if (w_rel_wr || w_tc) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    vg_trap_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk  (fclk),
        .rst  (rst),
        .load (w_accept),
        .en   (r_state == HELD),
        .tc   (w_tc)
    );

    assign w_err_set = (r_state == HELD) & w_tc;
    assign w_ovf_set = w_trap & (r_state != IDLE);

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_a            <= '0;
            r_wr           <= 1'b0;
            r_wdata        <= '0;
            r_err          <= 1'b0;
            r_ovf          <= 1'b0;
            r_vg_rdata     <= '0;
            r_vg_rdata_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.vg_a;
                r_wr    <= bus.vg_wr;
                r_wdata <= bus.vg_wdata;
            end
            // A status read clears the flags, but a same-cycle set takes priority
            r_err <= w_err_set | (r_err & ~w_stat_rd);
            r_ovf <= w_ovf_set | (r_ovf & ~w_stat_rd);
            if (w_resp_wr) begin
                r_vg_rdata     <= bus.emu_wdata;
                r_vg_rdata_vld <= 1'b1;
            end else if (r_state != IDLE && w_state_nxt == IDLE) begin
                r_vg_rdata_vld <= 1'b0;
            end
        end
    end

`ifdef TRAP_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.emu_wr && bus.emu_addr == REG_CNTL) begin
            r_cnt <= '0;
        end else if (w_accept && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_cnt = r_cnt;
`else
    assign w_cnt = '0;
`endif

    assign w_cnt_ext = 16'(w_cnt[CW-1:0]);

    always_comb begin
        w_rdata = '0;
        case (bus.emu_addr)
            REG_STAT: begin
                w_rdata[STAT_ACTIVE]           = w_active;
                w_rdata[STAT_WR]               = r_wr;
                w_rdata[STAT_ERR]              = r_err;
                w_rdata[STAT_OVF]              = r_ovf;
                w_rdata[STAT_A_MSB:STAT_A_LSB] = r_a;
            end
            REG_DATA: w_rdata = r_wdata;
            REG_CNTL: w_rdata = w_cnt_ext[7:0];
            REG_CNTH: w_rdata = w_cnt_ext[15:8];
            default:  w_rdata = '0;
        endcase
    end

    assign bus.emu_rdata    = w_rdata;
    assign bus.clr_nmi      = w_clr;
    assign bus.trap_active  = w_active;
    assign bus.vg_rdata     = r_vg_rdata;
    assign bus.vg_rdata_vld = r_vg_rdata_vld;

endmodule
`default_nettype wire

// File: tb/tb_vg_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vg_trap_ctrl
//  Purpose  : Directed and randomized self-checking bench for vg_trap_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vg_trap_ctrl;

    localparam int T     = 8;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    vg_trap_ctrl_if bus ();

    vg_trap_ctrl #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CNT_W)
    ) dut (
        .fclk (clk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: what the emulator should observe after each edge
    bit       m_valid = 0;
    bit       m_held, m_rel, m_wr, m_err, m_ovf, m_vld;
    int       m_age, m_cnt;
    bit [1:0] m_a;
    bit [7:0] m_wdata, m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_rdata(input logic [1:0] addr);
        logic [15:0] c;
        c = '0;
`ifdef TRAP_STATS_EN
        c = 16'(m_cnt);
`endif
        case (addr)
            2'd0:    return {m_held, m_wr, m_err, m_ovf, 2'b00, m_a};
            2'd1:    return m_wdata;
            2'd2:    return c[7:0];
            default: return c[15:8];
        endcase
    endfunction

    task automatic compare_model();
        if (!m_valid) return;
        chk("trap_active", 32'(bus.trap_active), 32'(m_held));
        chk("clr_nmi", 32'(bus.clr_nmi), 32'(m_rel));
        chk("vg_rdata_vld", 32'(bus.vg_rdata_vld), 32'(m_vld));
        chk("vg_rdata", 32'(bus.vg_rdata), 32'(m_rdata));
        chk("emu_rdata", 32'(bus.emu_rdata), 32'(model_rdata(bus.emu_addr)));
    endtask

    task automatic model_step();
        bit q, rel_wr, stat_rd, err_set, ovf_set;
        q       = bus.vg_rdwr_fclk && bus.fdd_mask[bus.vg_a] && bus.dos && bus.romnram;
        rel_wr  = bus.emu_wr && bus.emu_addr == 2'd0 && bus.emu_wdata[0];
        stat_rd = bus.emu_rd && bus.emu_addr == 2'd0;
        err_set = 0;
        ovf_set = 0;
        if (rst) begin
            m_valid = 1;
            m_held = 0; m_rel = 0; m_wr = 0; m_err = 0; m_ovf = 0; m_vld = 0;
            m_age = 0; m_cnt = 0; m_a = 0; m_wdata = 0; m_rdata = 0;
            return;
        end
        if (m_rel) begin
            ovf_set = q;
            m_rel   = 0;
            m_vld   = 0;
        end else if (m_held) begin
            ovf_set = q;
            if (bus.emu_wr && bus.emu_addr == 2'd1 && !m_wr) begin
                m_rdata = bus.emu_wdata;
                m_vld   = 1;
            end
            if (m_age == T - 1) err_set = 1;
            if (rel_wr || m_age == T - 1) begin
                m_held = 0;
                m_rel  = 1;
            end else begin
                m_age++;
            end
        end else if (q) begin
            m_a     = bus.vg_a;
            m_wr    = bus.vg_wr;
            m_wdata = bus.vg_wdata;
            m_held  = 1;
            m_age   = 0;
            if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
        end
        if (bus.emu_wr && bus.emu_addr == 2'd2) m_cnt = 0;
        m_err = err_set || (m_err && !stat_rd);
        m_ovf = ovf_set || (m_ovf && !stat_rd);
    endtask

    task automatic set_defaults();
        rst = 0;
        bus.vg_rdwr_fclk = 0; bus.vg_a = 0; bus.vg_wr = 0; bus.vg_wdata = 0;
        bus.fdd_mask = 0; bus.dos = 0; bus.romnram = 0;
        bus.emu_rd = 0; bus.emu_wr = 0; bus.emu_addr = 0; bus.emu_wdata = 0;
    endtask

    task automatic tick();
        #1;
        compare_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
        set_defaults();
    endtask

    task automatic trap(input logic [1:0] a, input logic wr, input logic [7:0] d, input logic [3:0] mask);
        bus.vg_rdwr_fclk = 1; bus.vg_a = a; bus.vg_wr = wr; bus.vg_wdata = d;
        bus.fdd_mask = mask; bus.dos = 1; bus.romnram = 1;
    endtask

    task automatic emu_write(input logic [1:0] addr, input logic [7:0] d);
        bus.emu_wr = 1; bus.emu_addr = addr; bus.emu_wdata = d;
    endtask

    task automatic read_chk(input string name, input logic [1:0] addr, input logic [7:0] exp);
        bus.emu_addr = addr;
        #1;
        chk(name, 32'(bus.emu_rdata), 32'(exp));
    endtask

    initial begin
        set_defaults();
        rst = 1;
        @(negedge clk);
        rst = 1; tick();
        chk("reset_active", 32'(bus.trap_active), 0);
        chk("reset_clr", 32'(bus.clr_nmi), 0);
        read_chk("reset_stat", 2'd0, 8'h00);

        // Write trap on drive 3
        trap(2'd3, 1'b1, 8'h5A, 4'b1000); tick();
        chk("wtrap_active", 32'(bus.trap_active), 1);
        read_chk("wtrap_stat", 2'd0, 8'hC3);
        read_chk("wtrap_data", 2'd1, 8'h5A);
        emu_write(2'd0, 8'h01); tick();
        chk("wtrap_clr", 32'(bus.clr_nmi), 1);
        tick();
        chk("wtrap_clr_end", 32'(bus.clr_nmi), 0);

        // Read trap with response data
        trap(2'd0, 1'b0, 8'h00, 4'b0001); tick();
        read_chk("rtrap_stat", 2'd0, 8'h80);
        emu_write(2'd1, 8'h80); tick();
        chk("rtrap_rdata", 32'(bus.vg_rdata), 32'h80);
        chk("rtrap_vld", 32'(bus.vg_rdata_vld), 1);
        emu_write(2'd0, 8'h01); tick();
        tick();
        chk("rtrap_vld_idle", 32'(bus.vg_rdata_vld), 0);
        chk("rtrap_rdata_kept", 32'(bus.vg_rdata), 32'h80);

        // Overflow from a second trap while held
        trap(2'd2, 1'b1, 8'h11, 4'b0100); tick();
        trap(2'd1, 1'b0, 8'h22, 4'b0010); tick();
        read_chk("ovf_stat", 2'd0, 8'hD2);
        read_chk("ovf_data", 2'd1, 8'h11);
        bus.emu_rd = 1; bus.emu_addr = 2'd0; tick();
        read_chk("ovf_cleared", 2'd0, 8'hC2);
        emu_write(2'd0, 8'h01); tick();
        tick();

        // Forced release by timeout
        trap(2'd1, 1'b0, 8'h00, 4'b0010); tick();
        for (int i = 0; i < 7; i++) tick();
        chk("to_still_held", 32'(bus.trap_active), 1);
        chk("to_no_clr_yet", 32'(bus.clr_nmi), 0);
        tick();
        chk("to_clr", 32'(bus.clr_nmi), 1);
        read_chk("to_stat", 2'd0, 8'h21);
        tick();
        chk("to_idle", 32'(bus.trap_active), 0);
        bus.emu_rd = 1; bus.emu_addr = 2'd0; tick();

        // Non-qualifying strobes
        trap(2'd2, 1'b1, 8'h33, 4'b1011); tick();
        chk("nq_mask", 32'(bus.trap_active), 0);
        trap(2'd2, 1'b1, 8'h33, 4'b0100); bus.dos = 0; tick();
        chk("nq_dos", 32'(bus.trap_active), 0);
        trap(2'd2, 1'b1, 8'h33, 4'b0100); bus.romnram = 0; tick();
        chk("nq_rom", 32'(bus.trap_active), 0);

        // Reset while held
        trap(2'd3, 1'b1, 8'h77, 4'b1000); tick();
        rst = 1; tick();
        chk("rst_held_active", 32'(bus.trap_active), 0);
        chk("rst_held_clr", 32'(bus.clr_nmi), 0);
        chk("rst_held_vld", 32'(bus.vg_rdata_vld), 0);
        chk("rst_held_rdata", 32'(bus.vg_rdata), 0);
        read_chk("rst_held_stat", 2'd0, 8'h00);
        tick();
        chk("rst_held_no_clr", 32'(bus.clr_nmi), 0);

`ifdef TRAP_STATS_EN
        for (int i = 0; i < 3; i++) begin
            trap(2'd0, 1'b1, 8'h00, 4'b0001); tick();
            emu_write(2'd0, 8'h01); tick();
            tick();
        end
        read_chk("stats_three", 2'd2, 8'h03);
        emu_write(2'd2, 8'h00); tick();
        read_chk("stats_clear", 2'd2, 8'h00);
`else
        trap(2'd0, 1'b1, 8'h00, 4'b0001); tick();
        read_chk("stats_absent", 2'd2, 8'h00);
        emu_write(2'd0, 8'h01); tick();
        tick();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.vg_rdwr_fclk = ($urandom_range(0, 3) == 0);
            bus.vg_a         = 2'($urandom);
            bus.vg_wr        = 1'($urandom);
            bus.vg_wdata     = 8'($urandom);
            bus.fdd_mask     = 4'($urandom);
            bus.dos          = ($urandom_range(0, 7) != 0);
            bus.romnram      = ($urandom_range(0, 7) != 0);
            bus.emu_rd       = ($urandom_range(0, 3) == 0);
            bus.emu_wr       = ($urandom_range(0, 3) == 0);
            bus.emu_addr     = 2'($urandom);
            bus.emu_wdata    = 8'($urandom);
            rst              = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
